// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake and hands one instruction per cycle to decode over
// valid/ready. A one-entry skid buffer catches the word that returns while
// decode is stalled; redirects from execute flush all in-flight work.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [10:0] if_ctrl
);

    // FETCH: request in flight at pc. HOLD: output and skid both full, no
    // request. DRAIN: a stale request must complete before the redirect
    // target can be requested (the address may not change mid-request).
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] tgt, tgt_n;
    logic        if_valid_n;
    logic [31:0] if_inst_n, if_pc_n;
    logic        skid_valid, skid_valid_n;
    logic [31:0] skid_inst, skid_inst_n;
    logic [31:0] skid_pc, skid_pc_n;

    logic        out_free;
    logic [31:0] redirect_tgt;

    assign out_free     = !if_valid || dec_ready;
    // Masking keeps the address word aligned whatever execute sends.
    assign redirect_tgt = redirect_pc & ~32'd3;

    // Memory-side outputs: no request in HOLD or while reset is asserted.
    assign imem_req  = !rst && (state != S_HOLD);
    assign imem_addr = rst ? RESET_PC : pc;

    // Decode control field extracted from the presented instruction.
    assign if_ctrl = {if_inst[30], if_inst[14:12], if_inst[6:0]};

    // Next-state, PC, output-register and skid update logic.
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_n      = state;
        pc_n         = pc;
        tgt_n        = tgt;
        if_valid_n   = if_valid;
        if_inst_n    = if_inst;
        if_pc_n      = if_pc;
        skid_valid_n = skid_valid;
        skid_inst_n  = skid_inst;
        skid_pc_n    = skid_pc;

        // Decode consumes the current word; a load below may refill it.
        if (if_valid && dec_ready) begin
            if_valid_n = 1'b0;
        end

        unique case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    pc_n = pc + 32'd4;
                    if (out_free) begin
                        if_valid_n = 1'b1;
                        if_inst_n  = imem_rdata;
                        if_pc_n    = pc;
                    end else begin
                        skid_valid_n = 1'b1;
                        skid_inst_n  = imem_rdata;
                        skid_pc_n    = pc;
                        state_n      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (dec_ready) begin
                    if_valid_n   = 1'b1;
                    if_inst_n    = skid_inst;
                    if_pc_n      = skid_pc;
                    skid_valid_n = 1'b0;
                    state_n      = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    pc_n    = tgt;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

        // Redirect overrides everything decided above in this cycle.
        if (redirect) begin
            if_valid_n   = 1'b0;
            skid_valid_n = 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_n    = redirect_tgt;
                        state_n = S_FETCH;
                    end else begin
                        pc_n    = pc;
                        tgt_n   = redirect_tgt;
                        state_n = S_DRAIN;
                    end
                end
                S_HOLD: begin
                    pc_n    = redirect_tgt;
                    state_n = S_FETCH;
                end
                S_DRAIN: begin
                    pc_n    = pc;
                    tgt_n   = redirect_tgt;
                    state_n = S_DRAIN;
                end
                default: begin
                    pc_n    = redirect_tgt;
                    state_n = S_FETCH;
                end
            endcase
        end
    end

    // Control state register: FSM, PC and the visible output register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_inst    <= 32'd0;
            if_pc      <= 32'd0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            if_valid   <= if_valid_n;
            if_inst    <= if_inst_n;
            if_pc      <= if_pc_n;
            skid_valid <= skid_valid_n;
        end
    end

    // Payload registers for the skid entry and the latched redirect target.
    always_ff @(posedge clk) begin
        // NOTE: these are only read when qualified by skid_valid or the DRAIN
        // state, both of which reset, so the payload itself needs no reset.
        tgt       <= tgt_n;
        skid_inst <= skid_inst_n;
        skid_pc   <= skid_pc_n;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a per-cycle vector table drives decode, memory and
// redirect inputs and checks the fetch-side outputs; a scoreboard queue holds
// the PCs decode must receive, in order, and is checked on every dequeue.
// A second instance with a high reset PC covers PC wrap-around.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [10:0] if_ctrl;
    logic        ack_en;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [10:0] w_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb[$];

    // Instruction memory contents: word 0 is a known ADDI, the rest are
    // address-dependent so stale or misordered data is visible.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [10:0] ctrl_of(input logic [31:0] w);
        return {w[30], w[14:12], w[6:0]};
    endfunction

    assign imem_ack   = imem_req && ack_en;
    assign imem_rdata = mem_word(imem_addr);
    assign w_ack      = w_req;
    assign w_rdata    = mem_word(w_addr);

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_ctrl     (if_ctrl)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .redirect    (1'b0),
        .redirect_pc (32'd0),
        .dec_ready   (1'b1),
        .if_valid    (w_valid),
        .if_inst     (w_inst),
        .if_pc       (w_pc),
        .if_ctrl     (w_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        dr;
        logic        ack;
        logic        rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic        push;
        logic [31:0] push_pc;
    } vec_t;

    function automatic vec_t mk(input logic dr, input logic ack, input logic rd,
                                input logic [31:0] rpc, input logic e_req,
                                input logic [31:0] e_addr, input logic e_val,
                                input logic [31:0] e_pc, input logic push,
                                input logic [31:0] push_pc);
        vec_t v;
        v.dr = dr; v.ack = ack; v.rd = rd; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
        v.push = push; v.push_pc = push_pc;
        return v;
    endfunction

    vec_t vecs[27];

    initial begin
        // Zero-wait stream, then decode stall with skid fill and release.
        vecs[0]  = mk(1, 1, 0, 0,        1, 32'h000, 0, 32'h000, 1, 32'h000);
        vecs[1]  = mk(1, 1, 0, 0,        1, 32'h004, 1, 32'h000, 1, 32'h004);
        vecs[2]  = mk(1, 1, 0, 0,        1, 32'h008, 1, 32'h004, 1, 32'h008);
        vecs[3]  = mk(0, 1, 0, 0,        1, 32'h00C, 1, 32'h008, 1, 32'h00C);
        vecs[4]  = mk(0, 1, 0, 0,        0, 32'h000, 1, 32'h008, 0, 32'h000);
        vecs[5]  = mk(0, 1, 0, 0,        0, 32'h000, 1, 32'h008, 0, 32'h000);
        vecs[6]  = mk(0, 1, 0, 0,        0, 32'h000, 1, 32'h008, 0, 32'h000);
        vecs[7]  = mk(1, 1, 0, 0,        0, 32'h000, 1, 32'h008, 0, 32'h000);
        vecs[8]  = mk(1, 1, 0, 0,        1, 32'h010, 1, 32'h00C, 1, 32'h010);
        vecs[9]  = mk(1, 1, 0, 0,        1, 32'h014, 1, 32'h010, 1, 32'h014);
        // Redirect with ack in the same cycle: the word for 0x18 is dropped.
        vecs[10] = mk(1, 1, 1, 32'h100,  1, 32'h018, 1, 32'h014, 0, 32'h000);
        vecs[11] = mk(1, 1, 0, 0,        1, 32'h100, 0, 32'h000, 1, 32'h100);
        // Redirect to 0x43 on an acked cycle lands on aligned 0x40.
        vecs[12] = mk(1, 1, 1, 32'h043,  1, 32'h104, 1, 32'h100, 0, 32'h000);
        vecs[13] = mk(1, 0, 0, 0,        1, 32'h040, 0, 32'h000, 0, 32'h000);
        // Redirect while the 0x40 request is outstanding: drain, then 0x200.
        vecs[14] = mk(1, 0, 1, 32'h203,  1, 32'h040, 0, 32'h000, 0, 32'h000);
        vecs[15] = mk(1, 0, 0, 0,        1, 32'h040, 0, 32'h000, 0, 32'h000);
        vecs[16] = mk(1, 0, 0, 0,        1, 32'h040, 0, 32'h000, 0, 32'h000);
        vecs[17] = mk(1, 1, 0, 0,        1, 32'h040, 0, 32'h000, 0, 32'h000);
        vecs[18] = mk(1, 1, 0, 0,        1, 32'h200, 0, 32'h000, 1, 32'h200);
        vecs[19] = mk(1, 1, 0, 0,        1, 32'h204, 1, 32'h200, 0, 32'h000);
        // Stall into HOLD, then redirect flushes output and skid.
        vecs[20] = mk(0, 1, 0, 0,        1, 32'h208, 1, 32'h204, 0, 32'h000);
        vecs[21] = mk(0, 1, 1, 32'h300,  0, 32'h000, 1, 32'h204, 0, 32'h000);
        vecs[22] = mk(0, 1, 0, 0,        1, 32'h300, 0, 32'h000, 1, 32'h300);
        // Slow memory: address held until ack.
        vecs[23] = mk(1, 0, 0, 0,        1, 32'h304, 1, 32'h300, 0, 32'h000);
        vecs[24] = mk(1, 0, 0, 0,        1, 32'h304, 0, 32'h000, 0, 32'h000);
        vecs[25] = mk(1, 1, 0, 0,        1, 32'h304, 0, 32'h000, 1, 32'h304);
        vecs[26] = mk(1, 0, 0, 0,        1, 32'h308, 1, 32'h304, 0, 32'h000);

        rst         = 1'b1;
        dec_ready   = 1'b0;
        ack_en      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst imem_req",  {31'd0, imem_req}, 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        check("rst if_valid",  {31'd0, if_valid}, 32'd0);
        check("rst if_inst",   if_inst, 32'd0);
        check("rst if_pc",     if_pc, 32'd0);
        check("rst if_ctrl",   {21'd0, if_ctrl}, 32'd0);

        for (int i = 0; i < 27; i++) begin
            logic [31:0] exp_pc;
            @(posedge clk);
            #1;
            rst         = 1'b0;
            dec_ready   = vecs[i].dr;
            ack_en      = vecs[i].ack;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            if (vecs[i].push) sb.push_back(vecs[i].push_pc);
            @(negedge clk);
            check($sformatf("c%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req)
                check($sformatf("c%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("c%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_val});
            if (vecs[i].e_val)
                check($sformatf("c%0d if_pc", i), if_pc, vecs[i].e_pc);
            if (i == 1)
                check("addi if_ctrl", {21'd0, if_ctrl}, {21'd0, 11'b000_0010011});
            if (if_valid && dec_ready) begin
                if (sb.size() == 0) begin
                    check($sformatf("c%0d unexpected dequeue pc", i), if_pc, 32'hDEAD_BEEF);
                end else begin
                    exp_pc = sb.pop_front();
                    check($sformatf("c%0d sb pc", i), if_pc, exp_pc);
                    check($sformatf("c%0d sb inst", i), if_inst, mem_word(exp_pc));
                    check($sformatf("c%0d sb ctrl", i), {21'd0, if_ctrl},
                          {21'd0, ctrl_of(mem_word(exp_pc))});
                end
            end
        end
        check("sb leftover entries", sb.size(), 32'd0);

        // Reset mid-request abandons all state.
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        ack_en    = 1'b0;
        dec_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst2 imem_req",  {31'd0, imem_req}, 32'd0);
        check("rst2 if_valid",  {31'd0, if_valid}, 32'd0);
        check("rst2 imem_addr", imem_addr, 32'd0);
        check("rst2 wrap addr", w_addr, 32'hFFFF_FFF8);
        check("rst2 wrap valid", {31'd0, w_valid}, 32'd0);

        // PC wrap from a high reset PC.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("wrap c0 addr", w_addr, 32'hFFFF_FFF8);
        check("wrap c0 valid", {31'd0, w_valid}, 32'd0);
        @(negedge clk);
        check("wrap c1 addr", w_addr, 32'hFFFF_FFFC);
        check("wrap c1 pc", w_pc, 32'hFFFF_FFF8);
        check("wrap c1 inst", w_inst, mem_word(32'hFFFF_FFF8));
        @(negedge clk);
        check("wrap c2 addr", w_addr, 32'h0000_0000);
        check("wrap c2 pc", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap c3 addr", w_addr, 32'h0000_0004);
        check("wrap c3 pc", w_pc, 32'h0000_0000);
        check("wrap c3 ctrl", {21'd0, w_ctrl}, {21'd0, 11'b000_0010011});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
